// File: rtl/program_counter_stack.sv
// Fetch-stage program counter with increment, jump, relative branch and CALL/RET
// through a small return-address stack; fault latches any stack over/underflow attempt.
module program_counter_stack #(
  parameter int unsigned       ADDR_W      = 11,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [2:0]                       op,
  input  logic [ADDR_W-1:0]                in,
  output logic [ADDR_W-1:0]                pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             stack_empty,
  output logic                             stack_full,
  output logic                             fault
);

  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  typedef enum logic [2:0] {
    OpHold   = 3'b000,
    OpInc    = 3'b001,
    OpLoad   = 3'b010,
    OpBranch = 3'b011,
    OpCall   = 3'b100,
    OpRet    = 3'b101,
    OpSoft   = 3'b110,
    OpRsvd   = 3'b111
  } op_e;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               fault_q, fault_d;
  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0]  stack_d [STACK_DEPTH];
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  top;
  logic               full, empty;

  assign pc_inc = pc_q + ADDR_W'(1);
  assign full   = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty  = (depth_q == '0);

  // Top-of-stack read; the loop keeps the index compare width-exact.
  always_comb begin
    top = '0;
    for (int i = 0; i < int'(STACK_DEPTH); i++) begin
      if (DEPTH_W'(i) == depth_q - DEPTH_W'(1)) top = stack_q[i];
    end
  end

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    fault_d = fault_q;
    stack_d = stack_q;
    if (enable) begin
      case (op_e'(op))
        OpInc:    pc_d = pc_inc;
        OpLoad:   pc_d = in;
        // Unsigned add of a two's-complement offset wraps identically to a signed add.
        OpBranch: pc_d = pc_q + in;
        OpCall: begin
          if (full) begin
            fault_d = 1'b1;
          end else begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
              if (DEPTH_W'(i) == depth_q) stack_d[i] = pc_inc;
            end
            pc_d    = in;
            depth_d = depth_q + DEPTH_W'(1);
          end
        end
        OpRet: begin
          if (empty) begin
            fault_d = 1'b1;
          end else begin
            pc_d    = top;
            depth_d = depth_q - DEPTH_W'(1);
          end
        end
        OpSoft: begin
          pc_d    = RESET_VEC;
          depth_d = '0;
          fault_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_VEC;
      depth_q <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) stack_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      fault_q <= fault_d;
      stack_q <= stack_d;
    end
  end

  assign pc          = pc_q;
  assign depth       = depth_q;
  assign stack_empty = empty;
  assign stack_full  = full;
  assign fault       = fault_q;

endmodule
